sprite_addr_gen: RTL and testbench
==================================

// Module: sprite_addr_gen
// PURPOSE
//  Parametrised, pipelined sprite-sheet address generator for the VGA object path.
//  - Maps the scaled VGA raster position onto a rectangular on-screen object.
//  - Emits the sprite-ROM address plus an enable that tells the screen mux to show the object.
//  - Adds over the first-generation generator: frame-synchronous shadow registers, multi-frame
//    animation, horizontal mirroring, and a fixed 2-cycle registered latency.
// PARAMETERS
//  SHEET_W      240  sprite-sheet row pitch in pixels (address stride per row)
//  ADDR_W       16   ROM address width
//  SCALE_NUM    3    raster scale numerator: h = (vga_h*SCALE_NUM) >> SCALE_SHIFT
//  SCALE_SHIFT  3    raster scale shift (denominator = 2**SCALE_SHIFT); v scaled identically
//  FRAMES       4    number of animation frames in the sheet, >=1
//  FRAME_PERIOD 8    frame_tick pulses per animation step, >=1
// PORTS
//  clk            in   1       pixel clock
//  rst            in   1       synchronous, active-high reset
//  vga_h          in   10      raster column
//  vga_v          in   10      raster row
//  pix_valid      in   1       raster inside active video
//  frame_tick     in   1       one-cycle pulse at start of vblank
//  anim_en        in   1       advance animation on frame_tick
//  anim_restart   in   1       force frame_idx to 0
//  mirror         in   1       flip object horizontally (shadowed)
//  mem_pivot_h    in   10      sheet column of frame 0 (shadowed)
//  mem_pivot_v    in   10      sheet row of frame 0 (shadowed)
//  frame_stride   in   10      sheet column offset between frames (shadowed)
//  pivot_h        in   10      object left edge, scaled coords (shadowed)
//  pivot_v        in   10      object top edge, scaled coords (shadowed)
//  width          in   10      object width, scaled pixels (shadowed)
//  height         in   10      object height, scaled pixels (shadowed)
//  addr           out  ADDR_W  sprite-ROM address
//  en             out  1       object covers current pixel
//  frame_idx      out  clog2(FRAMES) (min 1)  current animation frame
// BEHAVIOUR
//  Reset
//   - addr=0, en=0, frame_idx=0; tick counter, pipeline regs and all shadow regs = 0.
//   - Shadow width/height = 0, so en stays 0 until the first frame_tick.
//  Shadowing
//   - On frame_tick, all "(shadowed)" inputs are captured.
//   - Live inputs never affect a visible frame mid-scan, so there is no tearing.
//  Pipeline
//   - Stage 1 registers scaled h, v (11-bit intermediate products, truncated to 10 bits) and pix_valid.
//   - Stage 2 registers en and addr.
//   - Latency: exactly 2 clk from vga_h/vga_v/pix_valid to addr/en; one result per cycle.
//  Hit test (unsigned, 11-bit sums, no wrap)
//   - en = pix_valid_d && h >= pivot_h && h < pivot_h+width && v >= pivot_v && v < pivot_v+height.
//   - width=0 or height=0 gives en=0.
//  Address
//   - dh = h-pivot_h; dv = v-pivot_v; if mirror, dh = width-1-dh.
//   - addr = mem_pivot_h + frame_idx*frame_stride + dh + SHEET_W*(mem_pivot_v + dv).
//   - Computed at full precision, then truncated to ADDR_W.
//   - When en=0, addr=0.
//  Animation
//   - tick_cnt counts frame_tick pulses while anim_en=1.
//   - On a frame_tick with tick_cnt == FRAME_PERIOD-1: tick_cnt -> 0 and frame_idx -> (frame_idx+1) mod FRAMES.
//   - anim_en=0 freezes both tick_cnt and frame_idx.
//   - anim_restart sets frame_idx=0 and tick_cnt=0; it wins over a simultaneous frame_tick advance.
//   - A frame_idx change takes effect on the next cycle, together with the new shadow values.
//   - FRAMES=1: frame_idx stays 0.
//  Mid-operation reset
//   - rst has priority over every other input in the same cycle.
//   - en is 0 on the cycle after rst is asserted.
// TESTING
//  1. Address map
//     - Stimulus: frame_tick with pivot=(50,25), size=20x20, mem_pivot=0, mirror=0; then vga=(160,80), pix_valid=1.
//     - Required: 2 clk later en=1, addr=1210.
//  2. Mirror
//     - Stimulus: same as scenario 1 with mirror=1 latched on frame_tick.
//     - Required: addr=1209.
//  3. Right edge
//     - vga_h=186 (h=69) -> en=1, dh=19.
//     - vga_h=187 (h=70) -> en=0, addr=0.
//     - pix_valid=0 inside the box -> en=0.
//  4. Animation
//     - Stimulus: anim_en=1, frame_stride=20, FRAME_PERIOD=8; run 16 frame_ticks.
//     - Required: frame_idx=2; scenario-1 pixel gives addr=1250.
//     - Required: after 32 ticks with FRAMES=4, frame_idx wraps to 0.
//  5. Shadowing and priority
//     - Changing pivot_h between ticks leaves en/addr unchanged until the next frame_tick.
//     - anim_restart together with an advancing frame_tick gives frame_idx=0.
//  6. Reset
//     - Stimulus: assert rst while en=1 and frame_idx=3.
//     - Required: next cycle en=0, addr=0, frame_idx=0; en stays 0 until a frame_tick loads a nonzero size.

Source files
------------

// File: rtl/sprite_addr_gen.sv
// Pipelined sprite-sheet address generator for the VGA object path: scales the raster,
// hit-tests a shadowed on-screen rectangle and emits an animated, optionally mirrored ROM address.
module sprite_addr_gen #(
    parameter int SHEET_W      = 240,
    parameter int ADDR_W       = 16,
    parameter int SCALE_NUM    = 3,
    parameter int SCALE_SHIFT  = 3,
    parameter int FRAMES       = 4,
    parameter int FRAME_PERIOD = 8,
    localparam int FI_W        = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [9:0]        i_vga_h,
    input  logic [9:0]        i_vga_v,
    input  logic              i_pix_valid,
    input  logic              i_frame_tick,
    input  logic              i_anim_en,
    input  logic              i_anim_restart,
    input  logic              i_mirror,
    input  logic [9:0]        i_mem_pivot_h,
    input  logic [9:0]        i_mem_pivot_v,
    input  logic [9:0]        i_frame_stride,
    input  logic [9:0]        i_pivot_h,
    input  logic [9:0]        i_pivot_v,
    input  logic [9:0]        i_width,
    input  logic [9:0]        i_height,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_en,
    output logic [FI_W-1:0]   o_frame_idx
);

    localparam int TC_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    logic              r_mirror;
    logic [9:0]        r_memPivotH;
    logic [9:0]        r_memPivotV;
    logic [9:0]        r_frameStride;
    logic [9:0]        r_pivotH;
    logic [9:0]        r_pivotV;
    logic [9:0]        r_width;
    logic [9:0]        r_height;
    logic [TC_W-1:0]   r_tickCnt;
    logic [FI_W-1:0]   r_frameIdx;
    logic [9:0]        r_h;
    logic [9:0]        r_v;
    logic              r_validD;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;

    logic [10:0]       w_hProd;
    logic [10:0]       w_vProd;
    logic [9:0]        w_hScaled;
    logic [9:0]        w_vScaled;
    logic [10:0]       w_hEnd;
    logic [10:0]       w_vEnd;
    logic              w_hit;
    logic [9:0]        w_dh;
    logic [9:0]        w_dhEff;
    logic [9:0]        w_dv;
    logic [ADDR_W-1:0] w_addr;

    // Geometry is only sampled at vblank so a frame is always drawn with one consistent setup.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mirror      <= 1'b0;
            r_memPivotH   <= '0;
            r_memPivotV   <= '0;
            r_frameStride <= '0;
            r_pivotH      <= '0;
            r_pivotV      <= '0;
            r_width       <= '0;
            r_height      <= '0;
        end else if (i_frame_tick) begin
            r_mirror      <= i_mirror;
            r_memPivotH   <= i_mem_pivot_h;
            r_memPivotV   <= i_mem_pivot_v;
            r_frameStride <= i_frame_stride;
            r_pivotH      <= i_pivot_h;
            r_pivotV      <= i_pivot_v;
            r_width       <= i_width;
            r_height      <= i_height;
        end
    end

    // Restart beats a same-cycle advance; with FRAMES=1 the wrap compare keeps the index at 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_anim_restart) begin
            r_tickCnt  <= '0;
            r_frameIdx <= '0;
        end else if (i_frame_tick && i_anim_en) begin
            if (r_tickCnt == TC_W'(FRAME_PERIOD - 1)) begin
                r_tickCnt  <= '0;
                r_frameIdx <= (r_frameIdx == FI_W'(FRAMES - 1)) ? '0 : r_frameIdx + 1'b1;
            end else begin
                r_tickCnt <= r_tickCnt + 1'b1;
            end
        end
    end

    assign w_hProd   = {1'b0, i_vga_h} * 11'(SCALE_NUM);
    assign w_vProd   = {1'b0, i_vga_v} * 11'(SCALE_NUM);
    assign w_hScaled = 10'(w_hProd >> SCALE_SHIFT);
    assign w_vScaled = 10'(w_vProd >> SCALE_SHIFT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h      <= '0;
            r_v      <= '0;
            r_validD <= 1'b0;
        end else begin
            r_h      <= w_hScaled;
            r_v      <= w_vScaled;
            r_validD <= i_pix_valid;
        end
    end

    // Box ends are 11 bits wide so an object touching the right/bottom limit cannot wrap.
    assign w_hEnd  = {1'b0, r_pivotH} + {1'b0, r_width};
    assign w_vEnd  = {1'b0, r_pivotV} + {1'b0, r_height};
    assign w_hit   = r_validD
                   && (r_h >= r_pivotH) && ({1'b0, r_h} < w_hEnd)
                   && (r_v >= r_pivotV) && ({1'b0, r_v} < w_vEnd);
    assign w_dh    = r_h - r_pivotH;
    assign w_dv    = r_v - r_pivotV;
    assign w_dhEff = r_mirror ? (r_width - 10'd1 - w_dh) : w_dh;

    // Modular ADDR_W arithmetic gives the same low bits as a full-precision sum truncated afterwards.
    assign w_addr  = ADDR_W'(r_memPivotH)
                   + ADDR_W'(r_frameIdx) * ADDR_W'(r_frameStride)
                   + ADDR_W'(w_dhEff)
                   + ADDR_W'(SHEET_W) * (ADDR_W'(r_memPivotV) + ADDR_W'(w_dv));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en   <= 1'b0;
            r_addr <= '0;
        end else begin
            r_en   <= w_hit;
            r_addr <= w_hit ? w_addr : '0;
        end
    end

    assign o_addr      = r_addr;
    assign o_en        = r_en;
    assign o_frame_idx = r_frameIdx;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Self-checking bench for sprite_addr_gen: directed scenarios plus randomized traffic,
// all scored against a cycle-level behavioural model with a two-deep result queue.
module tb_sprite_addr_gen;

    localparam int SHEET_W      = 240;
    localparam int ADDR_W       = 16;
    localparam int SCALE_NUM    = 3;
    localparam int SCALE_SHIFT  = 3;
    localparam int FRAMES       = 4;
    localparam int FRAME_PERIOD = 8;
    localparam int FI_W         = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [9:0]        vgaH, vgaV;
    logic              pixValid, frameTick, animEn, animRestart, mirror;
    logic [9:0]        memPivotH, memPivotV, frameStride, pivotH, pivotV, width, height;
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic [FI_W-1:0]   frameIdx;

    int vectors     = 0;
    int miscompares = 0;

    int mdlMirror, mdlMemPivotH, mdlMemPivotV, mdlFrameStride;
    int mdlPivotH, mdlPivotV, mdlWidth, mdlHeight;
    int mdlFrameIdx, mdlTicks;
    int qEn[$];
    int qAddr[$];

    always #5 clock = ~clock;

    sprite_addr_gen #(
        .SHEET_W(SHEET_W), .ADDR_W(ADDR_W), .SCALE_NUM(SCALE_NUM), .SCALE_SHIFT(SCALE_SHIFT),
        .FRAMES(FRAMES), .FRAME_PERIOD(FRAME_PERIOD)
    ) dut (
        .i_clk(clock), .i_rst(reset), .i_vga_h(vgaH), .i_vga_v(vgaV), .i_pix_valid(pixValid),
        .i_frame_tick(frameTick), .i_anim_en(animEn), .i_anim_restart(animRestart),
        .i_mirror(mirror), .i_mem_pivot_h(memPivotH), .i_mem_pivot_v(memPivotV),
        .i_frame_stride(frameStride), .i_pivot_h(pivotH), .i_pivot_v(pivotV),
        .i_width(width), .i_height(height),
        .o_addr(addr), .o_en(en), .o_frame_idx(frameIdx)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int scaleCoord(input int c);
        return ((c * SCALE_NUM) % 2048) >> SCALE_SHIFT;
    endfunction

    function automatic void modelPixel(input int vh, input int vv, input int valid,
                                       output int expEn, output int expAddr);
        int h, v, dh, dv;
        h = scaleCoord(vh);
        v = scaleCoord(vv);
        expEn = 0;
        expAddr = 0;
        if (valid != 0 && h >= mdlPivotH && h < mdlPivotH + mdlWidth
                       && v >= mdlPivotV && v < mdlPivotV + mdlHeight) begin
            dh = h - mdlPivotH;
            dv = v - mdlPivotV;
            if (mdlMirror != 0) dh = mdlWidth - 1 - dh;
            expEn = 1;
            expAddr = (mdlMemPivotH + mdlFrameIdx * mdlFrameStride + dh
                       + SHEET_W * (mdlMemPivotV + dv)) % (1 << ADDR_W);
        end
    endfunction

    // One clock of stimulus: update the model with this cycle's inputs, clock, then score.
    task automatic applyStimulus();
        int e, a;
        if (reset) begin
            mdlMirror = 0; mdlMemPivotH = 0; mdlMemPivotV = 0; mdlFrameStride = 0;
            mdlPivotH = 0; mdlPivotV = 0; mdlWidth = 0; mdlHeight = 0;
            mdlFrameIdx = 0; mdlTicks = 0;
            foreach (qEn[i]) begin
                qEn[i] = 0;
                qAddr[i] = 0;
            end
            e = 0;
            a = 0;
        end else begin
            if (frameTick) begin
                mdlMirror = int'(mirror); mdlMemPivotH = int'(memPivotH);
                mdlMemPivotV = int'(memPivotV); mdlFrameStride = int'(frameStride);
                mdlPivotH = int'(pivotH); mdlPivotV = int'(pivotV);
                mdlWidth = int'(width); mdlHeight = int'(height);
            end
            if (animRestart) begin
                mdlFrameIdx = 0;
                mdlTicks = 0;
            end else if (frameTick && animEn) begin
                mdlTicks++;
                if (mdlTicks == FRAME_PERIOD) begin
                    mdlTicks = 0;
                    mdlFrameIdx = (mdlFrameIdx + 1) % FRAMES;
                end
            end
            modelPixel(int'(vgaH), int'(vgaV), int'(pixValid), e, a);
        end
        qEn.push_back(e);
        qAddr.push_back(a);
        @(posedge clock);
        #1;
        checkOutput("frame_idx", 32'(frameIdx), mdlFrameIdx);
        if (qEn.size() >= 2) begin
            checkOutput("en", 32'(en), qEn.pop_front());
            checkOutput("addr", 32'(addr), qAddr.pop_front());
        end
    endtask

    task automatic loadConfig(input int ph, input int pv, input int w, input int hgt,
                              input int mph, input int mpv, input int stride, input int mir);
        pivotH = 10'(ph); pivotV = 10'(pv); width = 10'(w); height = 10'(hgt);
        memPivotH = 10'(mph); memPivotV = 10'(mpv); frameStride = 10'(stride); mirror = 1'(mir);
        frameTick = 1'b1;
        applyStimulus();
        frameTick = 1'b0;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) begin
            frameTick = 1'b1;
            applyStimulus();
            frameTick = 1'b0;
            applyStimulus();
        end
    endtask

    task automatic probePixel(input string tag, input int vh, input int vv, input int valid,
                              input int expEn, input int expAddr);
        vgaH = 10'(vh); vgaV = 10'(vv); pixValid = 1'(valid);
        applyStimulus();
        pixValid = 1'b0;
        applyStimulus();
        checkOutput({tag, "_en"}, 32'(en), expEn);
        checkOutput({tag, "_addr"}, 32'(addr), expAddr);
    endtask

    initial begin
        reset = 1'b1; vgaH = '0; vgaV = '0; pixValid = 1'b0; frameTick = 1'b0;
        animEn = 1'b0; animRestart = 1'b0; mirror = 1'b0;
        memPivotH = '0; memPivotV = '0; frameStride = '0;
        pivotH = '0; pivotV = '0; width = '0; height = '0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_en", 32'(en), 0);
        checkOutput("reset_addr", 32'(addr), 0);
        checkOutput("reset_frame_idx", 32'(frameIdx), 0);
        reset = 1'b0;
        probePixel("no_size_yet", 160, 80, 1, 0, 0);

        loadConfig(50, 25, 20, 20, 0, 0, 20, 0);
        probePixel("addr_map", 160, 80, 1, 1, 1210);
        loadConfig(50, 25, 20, 20, 0, 0, 20, 1);
        probePixel("mirror", 160, 80, 1, 1, 1209);
        loadConfig(50, 25, 20, 20, 0, 0, 20, 0);
        probePixel("right_edge_in", 186, 80, 1, 1, 1219);
        probePixel("right_edge_out", 187, 80, 1, 0, 0);
        probePixel("pix_invalid", 160, 80, 0, 0, 0);

        animEn = 1'b1;
        tickN(16);
        checkOutput("anim_16", 32'(frameIdx), 2);
        probePixel("anim_addr", 160, 80, 1, 1, 1250);
        tickN(16);
        checkOutput("anim_wrap", 32'(frameIdx), 0);

        animEn = 1'b0;
        pivotH = 10'd100;
        probePixel("shadow_hold", 160, 80, 1, 1, 1210);
        tickN(1);
        probePixel("shadow_load", 160, 80, 1, 0, 0);
        pivotH = 10'd50;
        tickN(1);

        animEn = 1'b1;
        tickN(15);
        checkOutput("pre_restart", 32'(frameIdx), 1);
        animRestart = 1'b1;
        frameTick = 1'b1;
        applyStimulus();
        animRestart = 1'b0;
        frameTick = 1'b0;
        applyStimulus();
        checkOutput("restart_wins", 32'(frameIdx), 0);
        tickN(1);
        checkOutput("restart_cnt", 32'(frameIdx), 0);

        tickN(24);
        checkOutput("pre_reset_idx", 32'(frameIdx), 3);
        vgaH = 10'd160; vgaV = 10'd80; pixValid = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("pre_reset_en", 32'(en), 1);
        checkOutput("pre_reset_addr", 32'(addr), 1270);
        reset = 1'b1;
        applyStimulus();
        checkOutput("rst_en", 32'(en), 0);
        checkOutput("rst_addr", 32'(addr), 0);
        checkOutput("rst_idx", 32'(frameIdx), 0);
        reset = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("post_rst_en", 32'(en), 0);
        frameTick = 1'b1;
        applyStimulus();
        frameTick = 1'b0;
        applyStimulus();
        checkOutput("reload_en", 32'(en), 1);
        checkOutput("reload_addr", 32'(addr), 1210);
        pixValid = 1'b0;

        // Random traffic: live config churns between ticks to exercise shadowing and wrap.
        for (int n = 0; n < 4000; n++) begin
            reset       = ($urandom_range(0, 299) == 0);
            frameTick   = ($urandom_range(0, 11) == 0);
            animEn      = ($urandom_range(0, 3) != 0);
            animRestart = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) begin
                pivotH = 10'($urandom_range(0, 200));
                pivotV = 10'($urandom_range(0, 150));
                width = 10'($urandom_range(0, 80));
                height = 10'($urandom_range(0, 80));
                memPivotH = 10'($urandom);
                memPivotV = 10'($urandom);
                frameStride = 10'($urandom);
                mirror = 1'($urandom);
            end
            if ($urandom_range(0, 1) == 0) begin
                vgaH = 10'($urandom);
                vgaV = 10'($urandom);
            end else begin
                vgaH = 10'(((int'(pivotH) + $urandom_range(0, int'(width) + 2)) * 8 / 3) % 1024);
                vgaV = 10'(((int'(pivotV) + $urandom_range(0, int'(height) + 2)) * 8 / 3) % 1024);
            end
            pixValid = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
